// File: rtl/prog_target_lut.sv
// Programmable PC target / constant lookup table with registered reads,
// a hardware init sweep after reset, and a sticky write lock.
module prog_target_lut #(
   parameter int D        = 12,
   parameter int A        = 5,
   parameter int HALT_IDX = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd_en,
   input  logic [A-1:0] rd_addr,
   output logic [D-1:0] rd_target,
   output logic         rd_valid,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [A-1:0] wr_addr,
   input  logic [D-1:0] wr_data,
   input  logic         lock,
   output logic         locked,
   output logic         wr_err,
   output logic         init_done
);

   typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

   localparam logic [A-1:0] HALT_ADDR = A'(HALT_IDX);
   localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};

   state_t       state_r;
   state_t       state_nxt_s;
   logic [A-1:0] cnt_r;
   logic         locked_r;
   logic         wr_err_r;
   logic [D-1:0] rd_target_r;
   logic         rd_valid_r;
   logic [D-1:0] mem_r [2**A];

   logic         run_s;
   logic         wr_acc_s;
   logic         wr_do_s;

   assign run_s    = (state_r == RUN);
   assign wr_acc_s = wr_valid && run_s;
   assign wr_do_s  = wr_acc_s && !locked_r;

   // State register and init counter; cnt parks at the last index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= INIT;
         cnt_r   <= {A{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == INIT && cnt_r != LAST_ADDR) begin
            cnt_r <= cnt_r + {{(A-1){1'b0}}, 1'b1};
         end
      end
   end

   // Next-state: leave INIT on the edge that writes the last index.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         INIT: begin
            if (cnt_r == LAST_ADDR) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = INIT;
            end
         end
         RUN:     state_nxt_s = RUN;
         default: state_nxt_s = INIT;
      endcase
   end

   // State-decoded outputs; both follow the state flop directly.
   always_comb begin
      wr_ready  = 1'b0;
      init_done = 1'b0;
      case (state_r)
         RUN: begin
            wr_ready  = 1'b1;
            init_done = 1'b1;
         end
         default: begin
            wr_ready  = 1'b0;
            init_done = 1'b0;
         end
      endcase
   end

   // Table storage: init sweep fill, then unlocked run-time writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         // contents are rebuilt by the init sweep
      end else if (state_r == INIT) begin
         mem_r[cnt_r] <= (cnt_r == HALT_ADDR) ? {D{1'b1}} : {D{1'b0}};
      end else if (wr_do_s) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Lock, dropped-write flag and write-first registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         locked_r    <= 1'b0;
         wr_err_r    <= 1'b0;
         rd_target_r <= {D{1'b0}};
         rd_valid_r  <= 1'b0;
      end else begin
         if (run_s && lock) begin
            locked_r <= 1'b1;
         end
         wr_err_r <= wr_acc_s && locked_r;
         if (run_s && rd_en) begin
            rd_valid_r  <= 1'b1;
            rd_target_r <= (wr_do_s && wr_addr == rd_addr) ? wr_data : mem_r[rd_addr];
         end else begin
            rd_valid_r <= 1'b0;
         end
      end
   end

   assign rd_target = rd_target_r;
   assign rd_valid  = rd_valid_r;
   assign locked    = locked_r;
   assign wr_err    = wr_err_r;

endmodule

// File: tb/tb_prog_target_lut.sv
// Directed self-checking bench for prog_target_lut.
module tb_prog_target_lut;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [11:0] rd_target;
   logic        rd_valid;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_addr;
   logic [11:0] wr_data;
   logic        lock;
   logic        locked;
   logic        wr_err;
   logic        init_done;

   int errors = 0;
   int checks = 0;

   prog_target_lut dut (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_target (rd_target),
      .rd_valid  (rd_valid),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .lock      (lock),
      .locked    (locked),
      .wr_err    (wr_err),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".rd_target"}, 32'(rd_target), 32'h0);
      check({tag, ".rd_valid"},  32'(rd_valid),  32'h0);
      check({tag, ".wr_ready"},  32'(wr_ready),  32'h0);
      check({tag, ".locked"},    32'(locked),    32'h0);
      check({tag, ".wr_err"},    32'(wr_err),    32'h0);
      check({tag, ".init_done"}, 32'(init_done), 32'h0);
   endtask

   task automatic idle();
      rd_en = 1'b0; rd_addr = 5'd0;
      wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 12'h000;
      lock = 1'b0;
   endtask

   task automatic read_check(input logic [4:0] a, input logic [11:0] exp, input string tag);
      rd_en = 1'b1; rd_addr = a;
      step();
      check({tag, ".valid"}, 32'(rd_valid), 32'h1);
      check({tag, ".data"},  32'(rd_target), 32'(exp));
      rd_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step();
      step();
      check_reset_outputs("reset");

      // Init sweep with writes, reads and lock hammering the blocked ports
      reset = 1'b0;
      wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 12'h123;
      rd_en = 1'b1; rd_addr = 5'd5; lock = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         step();
         check($sformatf("init.done@%0d", e),  32'(init_done), (e == 32) ? 32'h1 : 32'h0);
         check($sformatf("init.ready@%0d", e), 32'(wr_ready),  (e == 32) ? 32'h1 : 32'h0);
         check($sformatf("init.rdv@%0d", e),   32'(rd_valid),  32'h0);
      end
      idle();
      check("init.locked", 32'(locked), 32'h0);

      for (int a = 0; a < 32; a++) begin
         read_check(5'(a), (a == 20) ? 12'hFFF : 12'h000, $sformatf("sweep@%0d", a));
      end

      // rd_target holds its value when no read is issued
      read_check(5'd20, 12'hFFF, "hold.pre");
      step();
      check("hold.valid", 32'(rd_valid),  32'h0);
      check("hold.data",  32'(rd_target), 32'hFFF);

      // Basic write then back-to-back reads
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 12'h0FF;
      step();
      wr_addr = 5'd4; wr_data = 12'h080;
      step();
      wr_valid = 1'b0;
      read_check(5'd3, 12'h0FF, "basic.a3");
      read_check(5'd4, 12'h080, "basic.a4");

      // Write-first collision
      wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 12'h00F;
      rd_en = 1'b1; rd_addr = 5'd10;
      step();
      idle();
      check("coll.valid", 32'(rd_valid),  32'h1);
      check("coll.data",  32'(rd_target), 32'h00F);
      read_check(5'd10, 12'h00F, "coll.after");

      // Lock with a same-edge write that must still land
      wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 12'h0AB; lock = 1'b1;
      step();
      idle();
      check("lock.locked", 32'(locked), 32'h1);
      check("lock.noerr",  32'(wr_err), 32'h0);
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 12'h123;
      step();
      idle();
      check("lock.err1",   32'(wr_err), 32'h1);
      step();
      check("lock.err0",   32'(wr_err), 32'h0);
      check("lock.sticky", 32'(locked), 32'h1);
      // Two consecutive dropped writes; second one collides with a read
      wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 12'h111;
      step();
      check("lock.cons1", 32'(wr_err), 32'h1);
      wr_addr = 5'd3; wr_data = 12'h555; rd_en = 1'b1; rd_addr = 5'd3;
      step();
      idle();
      check("lock.cons2",    32'(wr_err),    32'h1);
      check("lock.nofwd",    32'(rd_target), 32'h0FF);
      step();
      check("lock.cons_end", 32'(wr_err),    32'h0);
      read_check(5'd3, 12'h0FF, "lock.a3");
      read_check(5'd4, 12'h080, "lock.a4");
      read_check(5'd7, 12'h0AB, "lock.a7");

      // Mid-run reset for one cycle
      reset = 1'b1;
      step();
      check_reset_outputs("mreset");
      reset = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         step();
         check($sformatf("reinit.done@%0d", e), 32'(init_done), (e == 32) ? 32'h1 : 32'h0);
      end
      check("reinit.locked", 32'(locked), 32'h0);
      read_check(5'd3,  12'h000, "reinit.a3");
      read_check(5'd20, 12'hFFF, "reinit.a20");
      read_check(5'd7,  12'h000, "reinit.a7");

      // Unlocked again: writes land and raise no error
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 12'h321;
      step();
      idle();
      check("unlock.noerr", 32'(wr_err), 32'h0);
      read_check(5'd3, 12'h321, "unlock.a3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prog_target_lut.md
# prog_target_lut

Programmable successor to the fixed PC lookup table. It holds 2^A entries of D bits each, used as branch targets and load-immediate constants, and adds a write port so software or a loader can fill entries at run time. Reads are registered. After reset, a hardware init sequence walks the whole table, and a lock bit freezes the contents once loading is finished. It sits between the instruction decoder's 5-bit LUT index field and the fetch unit's PC-load and immediate paths.

## Interface
- D, 12, entry width (target / constant bits)
- A, 5, index width; depth = 2^A
- HALT_IDX, 20, entry initialised to all-ones (halt target); must be < 2^A

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; restarts the init sequence
- rd_en  in  1  read request this cycle
- rd_addr  in  A  read index
- rd_target  out  D  registered read data
- rd_valid  out  1  rd_target holds data for a read accepted last cycle
- wr_valid  in  1  write request
- wr_ready  out  1  write port able to accept
- wr_addr  in  A  write index
- wr_data  in  D  write value
- lock  in  1  one-cycle or level request to lock the table (sticky until reset)
- locked  out  1  table is locked
- wr_err  out  1  one-cycle pulse: a write was accepted while locked and dropped
- init_done  out  1  table is initialised and serving

## Operation
- The FSM has two states, INIT and RUN.
- INIT:
  - While reset is high: state=INIT, init counter cnt=0, locked=0, no memory writes.
  - Each edge with reset low: mem[cnt] <= (cnt==HALT_IDX ? all-ones : 0), then cnt <= cnt+1.
  - On the edge that writes index 2^A-1, state <= RUN. cnt does not wrap.
  - During INIT: wr_ready=0, writes are ignored, rd_en is ignored, and rd_valid=0.
- RUN:
  - wr_ready=1 (combinational, equal to state==RUN).
  - A write is accepted when wr_valid && wr_ready.
  - If not locked: mem[wr_addr] <= wr_data.
  - If locked: memory is unchanged and wr_err=1 on the next cycle.
- Read, RUN only: if rd_en, then rd_target <= mem[rd_addr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_target holds its last value.
- Read/write collision: an unlocked write accepted on the same edge as a read of the same address forwards the data, so rd_target <= wr_data (write-first).
- Lock:
  - The first edge in RUN with lock=1 sets locked <= 1.
  - A write accepted on that same edge is still performed; lock takes effect from the next edge.
  - lock is ignored during INIT.
  - Only reset clears locked.
- Widths: addresses use the full A bits, so there is no out-of-range index. Data is stored unmodified, with no sign extension.

## Timing
- Reset values of outputs: rd_target=0, rd_valid=0, wr_ready=0, locked=0, wr_err=0, init_done=0.
- Init latency: init_done rises exactly 2^A edges after the first edge with reset low (32 for the default A). init_done is registered and equals state==RUN.
- Read latency is 1 cycle: rd_addr is sampled at edge N and rd_target/rd_valid are valid after edge N. Back-to-back reads are allowed every cycle.
- Write takes effect at the accepting edge. A read issued on the following cycle sees the new value.
- wr_err pulses high for exactly one cycle per dropped write. Consecutive dropped writes give consecutive high cycles.
- Reset mid-operation, in any state and any cycle: on the next edge all outputs return to reset values and the table is fully re-initialised. Prior contents and the lock are lost.
- Reset is asserted for at least 1 cycle. Holding reset high for multiple cycles keeps cnt=0.

## Test plan
- Init sweep: assert reset 2 cycles, release, count edges. init_done must rise exactly at edge 32. Reading addresses 0..31 must return 0x000 everywhere except addr 20, which returns 0xFFF, with rd_valid high one cycle after each rd_en.
- Basic write/read: write 0x0FF to addr 3 and 0x080 to addr 4, then read addr 3 and addr 4 back-to-back. Expect 0x0FF, then 0x080, on consecutive cycles.
- Collision: on the same edge, write addr 10 = 0x00F with rd_en on addr 10. The next cycle must show rd_target=0x00F and rd_valid=1.
- INIT blocking: drive wr_valid with addr 5 = 0x123 and rd_en during cycles 0..31 after reset release. Expect wr_ready=0 and rd_valid=0 throughout. After init_done, reading addr 5 returns 0x000.
- Lock: write addr 3 = 0x0FF, pulse lock, then write addr 3 = 0x123. Expect locked=1, a one-cycle wr_err pulse, and a read of addr 3 still returning 0x0FF. A write issued on the same edge as lock must land.
- Mid-run reset: after the lock test, assert reset for 1 cycle. Expect locked=0, init_done=0, and a 32-cycle re-init. Addr 3 then reads 0x000 and addr 20 reads 0xFFF.
